// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer for the accumulator datapath: drives the
// datapath strobes, the ULA operation code and a single-port memory handshake.
module control_unit #(
    parameter int unsigned ULA_LATENCY = 1,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       run,
    input  logic [7:0] ir_value,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       addr_sel,
    output logic       pc_inc,
    output logic       ir_reg_write,
    output logic       mar_reg_write,
    output logic       gp_reg_write,
    output logic       gp_reg_read,
    output logic       latch_ula,
    output logic       grab_ula,
    output logic [3:0] ula_operation,
    output logic       halted,
    output logic       fault,
    output logic       illegal_op
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_OPER, S_EXEC, S_WB, S_HALT, S_FAULT
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_ALU = 4'h2;
    localparam logic [3:0] OP_STO = 4'h3;
    localparam logic [3:0] OP_HLT = 4'hF;

    state_t      state_r;
    state_t      state_next_s;
    logic [7:0]  wait_r;
    logic [2:0]  lat_r;
    logic [3:0]  opcode_s;
    logic        wait_limit_s;
    logic        lat_last_s;
    logic        mem_state_s;

    assign opcode_s     = ir_value[7:4];
    assign wait_limit_s = (wait_r == 8'(MEM_TIMEOUT));
    assign lat_last_s   = (lat_r == 3'(ULA_LATENCY - 1));
    assign mem_state_s  = (state_r == S_FETCH) || (state_r == S_OPER) || (state_r == S_WB);

    // State register plus wait/latency counters; both counters clear on any state change.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= S_IDLE;
            wait_r  <= 8'd0;
            lat_r   <= 3'd0;
        end else begin
            state_r <= state_next_s;
            if (state_next_s != state_r) begin
                wait_r <= 8'd0;
                lat_r  <= 3'd0;
            end else begin
                wait_r <= mem_state_s ? (wait_r + 8'd1) : wait_r;
                lat_r  <= (state_r == S_EXEC) ? (lat_r + 3'd1) : lat_r;
            end
        end
    end

    // Next-state and strobe decode; ready-qualified strobes are Mealy.
    always_comb begin
        state_next_s  = state_r;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        addr_sel      = 1'b0;
        pc_inc        = 1'b0;
        ir_reg_write  = 1'b0;
        mar_reg_write = 1'b0;
        gp_reg_write  = 1'b0;
        gp_reg_read   = 1'b0;
        latch_ula     = 1'b0;
        grab_ula      = 1'b0;
        ula_operation = 4'h0;
        halted        = 1'b0;
        fault         = 1'b0;
        illegal_op    = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (run) begin
                    state_next_s = S_FETCH;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_reg_write = 1'b1;
                    pc_inc       = 1'b1;
                    state_next_s = S_DECODE;
                end else if (wait_limit_s) begin
                    state_next_s = S_FAULT;
                end else begin
                    state_next_s = S_FETCH;
                end
            end
            S_DECODE: begin
                case (opcode_s)
                    OP_NOP:                 state_next_s = S_FETCH;
                    OP_LDI, OP_ALU, OP_STO: state_next_s = S_OPER;
                    OP_HLT:                 state_next_s = S_HALT;
                    default: begin
                        illegal_op   = 1'b1;
                        state_next_s = S_FETCH;
                    end
                endcase
            end
            S_OPER: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    pc_inc = 1'b1;
                    case (opcode_s)
                        OP_LDI: begin
                            gp_reg_write = 1'b1;
                            state_next_s = S_FETCH;
                        end
                        OP_ALU: state_next_s = S_EXEC;
                        OP_STO: begin
                            mar_reg_write = 1'b1;
                            state_next_s  = S_WB;
                        end
                        default: state_next_s = S_FETCH;
                    endcase
                end else if (wait_limit_s) begin
                    state_next_s = S_FAULT;
                end else begin
                    state_next_s = S_OPER;
                end
            end
            S_EXEC: begin
                // Operand stays on the bus for the whole ULA evaluation.
                mem_read      = 1'b1;
                gp_reg_read   = 1'b1;
                ula_operation = ir_value[3:0];
                if (lat_last_s) begin
                    // A reset arriving on the capture cycle must not corrupt the result latch.
                    latch_ula    = ~reset;
                    state_next_s = S_FETCH;
                end else begin
                    state_next_s = S_EXEC;
                end
            end
            S_WB: begin
                addr_sel  = 1'b1;
                mem_write = 1'b1;
                grab_ula  = 1'b1;
                if (mem_ready) begin
                    state_next_s = S_FETCH;
                end else if (wait_limit_s) begin
                    state_next_s = S_FAULT;
                end else begin
                    state_next_s = S_WB;
                end
            end
            S_HALT: begin
                halted       = 1'b1;
                state_next_s = S_HALT;
            end
            S_FAULT: begin
                fault        = 1'b1;
                state_next_s = S_FAULT;
            end
            default: state_next_s = S_IDLE;
        endcase
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Sequencer for the processor datapath: fetch, decode and execute against the accumulator register, ULA, ULA result latch, PC, MAR and IR.
- Drives every datapath strobe, the ULA operation code and a single-port memory handshake.
- Sits beside the datapath; IR contents come back as the decode input.

Parameters:
ULA_LATENCY, 1, cycles spent in EXEC before latch_ula pulses (1..7)
MEM_TIMEOUT, 15, max cycles waiting on mem_ready before fault (1..255)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
run  input  1  level; leaves IDLE when high
ir_value  input  8  IR contents; [7:4] opcode, [3:0] ULA op field
mem_ready  input  1  memory completes current read/write this cycle
mem_read  output  1  memory read request; data_bus_in held valid while high after ready
mem_write  output  1  memory write request (data from ULA result register)
addr_sel  output  1  0 = address from pc_count, 1 = from mar_value
pc_inc  output  1  PC increment strobe
ir_reg_write  output  1  load IR from data_bus_in
mar_reg_write  output  1  load MAR from data_bus_in
gp_reg_write  output  1  load accumulator from data_bus_in
gp_reg_read  output  1  accumulator drives ULA operand (high in EXEC)
latch_ula  output  1  capture ULA result into latch/result register
grab_ula  output  1  result register drives data_bus_out
ula_operation  output  4  ULA op; ir_value[3:0] in EXEC, else 0
halted  output  1  high in HALT
fault  output  1  high in FAULT
illegal_op  output  1  one-cycle pulse on unknown opcode

Behaviour:
- Opcodes: 0x0 NOP, 0x1 LDI (next byte -> A), 0x2 ALU (A op next byte, op = ir[3:0]), 0x3 STO (next byte = address, store result), 0xF HLT; all others illegal.
- Reset: state IDLE, all outputs 0, wait/latency counters 0. Reset overrides everything, mid-transaction included: requests drop the next cycle.
- State outputs are Moore; strobes marked "on ready" are Mealy, asserted the same cycle as mem_ready.
- IDLE: run=1 -> FETCH next cycle.
- FETCH: mem_read=1, addr_sel=0. On ready: ir_reg_write=1, pc_inc=1 -> DECODE.
- DECODE (1 cycle, no requests):
  - NOP -> FETCH
  - LDI/ALU/STO -> OPER
  - HLT -> HALT
  - illegal: illegal_op=1 -> FETCH
- OPER: mem_read=1, addr_sel=0. On ready: pc_inc=1, then by opcode:
  - LDI: gp_reg_write=1 -> FETCH
  - ALU -> EXEC
  - STO: mar_reg_write=1 -> WB
- EXEC: mem_read stays 1 (operand held on bus); gp_reg_read=1; ula_operation=ir[3:0].
  - Counter runs 0..ULA_LATENCY-1.
  - On last count: latch_ula=1 -> FETCH.
- WB: addr_sel=1, mem_write=1, grab_ula=1. On ready -> FETCH.
- HALT: halted=1, no requests; exits only by reset.
- FAULT: fault=1, no requests; exits only by reset.
- Memory timeout, in FETCH, OPER and WB:
  - Wait counter clears on state entry and increments each cycle without ready.
  - When it reaches MEM_TIMEOUT with ready still low -> FAULT.
  - Ready in the same cycle as the limit counts as success.
- Signal rules:
  - mem_read and mem_write are never high together.
  - pc_inc is at most one cycle per memory ready.
  - run dropping mid-instruction has no effect; run is sampled only in IDLE.
- Timing: IR is loaded at the end of FETCH, so DECODE uses the registered ir_value.

Test Plan:
- Reset with run=1 and mem_ready=1, then release -> IDLE for 1 cycle, FETCH next; all outputs 0 during reset.
- Memory returns 0x00 with ready on first cycle -> FETCH(1) DECODE(1) FETCH; exactly one pc_inc per instruction.
- Program 0x10,0x05 then 0x25,0x03 (ULA_LATENCY=1) -> gp_reg_write on the 0x05 ready; EXEC shows ula_operation=5 and gp_reg_read; latch_ula pulses one cycle; 4 pc_inc total.
- Program 0x30,0x80 with ready delayed 3 cycles in WB -> mar_reg_write once; mem_write, grab_ula, addr_sel high 4 cycles; then FETCH.
- mem_ready held low in FETCH with MEM_TIMEOUT=15 -> FAULT entered after 15 wait cycles, fault=1 and sticky. Ready at cycle 15 -> DECODE instead.
- Opcode 0x70 -> illegal_op single pulse, back to FETCH. Opcode 0xF0 -> halted=1, no mem activity for 20 cycles. Reset mid-EXEC -> IDLE next cycle, latch_ula never pulses.
